hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage WISC-SP22 core.
- Decides per cycle which pipeline registers hold, which receive a bubble (NOP), and which are flushed. Causes: data-memory misses, instruction-memory misses, taken-redirects from EX, load-use hazards the EX-EX/MEM-EX forwarding network cannot cover, and HALT retirement.
- Sits beside the forwarding unit; its outputs drive the enable and bubble inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- OpCode_ID  in  5  opcode of the instruction in ID
- read1RegSel_ID  in  3  Rs of the ID instruction
- read2RegSel_ID  in  3  Rt of the ID instruction
- Write_register_EX  in  3  destination of the EX instruction
- RegWrite_EX  in  1  EX instruction writes the register file
- MemRead_EX  in  1  EX instruction is a load
- link_EX  in  1  EX instruction writes R7 (JAL/JALR)
- Write_register_MEM  in  3  destination of the MEM instruction
- MemRead_MEM  in  1  MEM instruction is a load
- imem_stall  in  1  instruction memory busy this cycle
- imem_done  in  1  instruction fetch data valid this cycle
- dmem_stall  in  1  data memory busy this cycle
- dmem_done  in  1  data access completes this cycle
- redirect_EX  in  1  taken branch/jump resolved in EX
- halt_WB  in  1  HALT is retiring in WB
- hold_pc  out  1  PC keeps its value
- hold_ifid  out  1  IF/ID keeps its value
- hold_idex  out  1  ID/EX keeps its value
- hold_exmem  out  1  EX/MEM keeps its value
- bubble_ifid  out  1  IF/ID loads a NOP
- bubble_idex  out  1  ID/EX loads a NOP
- bubble_memwb  out  1  MEM/WB loads a NOP
- halted  out  1  core is stopped
- stall_cnt  out  CNT_W  cycles in which hold_pc was high

Behaviour:
- States: RUN, DWAIT, IWAIT, IWAIT_KILL, HALTED. The state register and stall_cnt reset asynchronously to RUN and 0.
- Outputs are combinational from state and inputs. With rst high, all outputs are 0 except stall_cnt, which is 0.
- Priority within RUN/IWAIT: dmem_stall, then redirect_EX, then hazard, then imem_stall.
- Operand use decode:
  - uses_rs is false for HALT, NOP, J, JAL, siic, RTI, LBI, SLBI.
  - uses_rt is true for ST, STU, 11011, 11010, 111xx.
  - early_rs (Rs read in ID) is true for 011xx, JR 00101, JALR 00111.
  - Rs match with EX includes the case Rs==7 & link_EX.
- Hazard condition is any of:
  - load-use: MemRead_EX & RegWrite_EX & (uses_rs & Rs match EX | uses_rt & Rt match EX);
  - early_rs & RegWrite_EX & Rs match EX;
  - early_rs & MemRead_MEM & Rs==Write_register_MEM.
- Hazard response, same cycle: hold_pc=1, hold_ifid=1, bubble_idex=1. Repeats each cycle until the condition clears, so an early_rs after a load costs 2 bubbles.
- DWAIT:
  - Entered from RUN/IWAIT when dmem_stall=1.
  - Response: hold_pc, hold_ifid, hold_idex, hold_exmem all 1; bubble_memwb=1. redirect_EX and hazards are ignored.
  - Exits to RUN on the cycle dmem_done=1. That cycle still holds; the first cycle in RUN re-evaluates redirect_EX and hazards.
  - If imem is still busy on exit, go to IWAIT instead.
- IWAIT:
  - Entered when imem_stall=1 with no higher-priority event.
  - Response: hold_pc=1, bubble_ifid=1. Later stages advance.
  - imem_done returns to RUN; the fetched instruction is accepted normally.
- Redirect:
  - In RUN: bubble_ifid=1, bubble_idex=1 for one cycle. The PC loads the target, so hold_pc=0.
  - In IWAIT: bubble_ifid=1, bubble_idex=1, go to IWAIT_KILL.
- IWAIT_KILL:
  - Response: hold_pc=1, bubble_ifid=1.
  - On imem_done, discard the wrong-path fetch (bubble_ifid=1), release hold_pc so the target loads, and go to RUN.
  - A dmem_stall arriving in IWAIT_KILL is served in DWAIT, then returns to IWAIT_KILL.
- HALTED:
  - Entered from any state on halt_WB=1 (highest priority, including over dmem_stall).
  - Response: halted=1, all holds 1, all bubbles 0. Left only by rst.
- stall_cnt increments on every cycle with hold_pc=1 and saturates at all-ones. It is frozen in HALTED.
- Reset mid-miss: the state returns to RUN immediately. A late dmem_done/imem_done is ignored in RUN.

Decomposition:
- Shared package hazard_pkg:
  - state encoding constants (3 bits);
  - opcode constants (HALT, NOP, J, JAL, JR, JALR, LBI, SLBI, ST, STU, siic, RTI, branch prefix 011).
- One sub-module, src_use_decode: OpCode_ID -> uses_rs, uses_rt, early_rs. It is pure combinational and reusable by the forwarding unit.

Test Plan:
- LD R1 in EX (MemRead_EX=1, Write_register_EX=1) and ADD R2,R1,R3 in ID -> one cycle of hold_pc=hold_ifid=bubble_idex=1, then all 0; stall_cnt=1.
- BEQZ R4 in ID, ADDI R4 in EX -> 1 bubble; the ADDI then moves to MEM with MemRead_MEM=0 -> no further stall. With LD R4 instead -> 2 consecutive bubbles, stall_cnt=2.
- dmem_stall high 4 cycles, dmem_done in 4th, redirect_EX high throughout -> 4 cycles of full hold plus bubble_memwb. Then exactly one redirect flush cycle (bubble_ifid=bubble_idex=1).
- imem_stall, redirect_EX on 2nd wait cycle, imem_done 3 cycles later -> IWAIT_KILL. On done, bubble_ifid=1 and hold_pc=0; the next fetch is the target.
- halt_WB=1 during DWAIT -> HALTED next cycle, halted=1, all holds 1. stall_cnt is frozen; pulsing rst clears everything to 0/RUN.
- Force stall_cnt near all-ones (CNT_W=4, 16 stalled cycles) -> saturates at 15 and does not wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants for the hazard controller
// Purpose: FSM state encoding, WISC-SP22 opcode constants and the per-cycle
//          pipeline control bundle used by hazard_ctrl and src_use_decode.
// Ports:   none (package).
package hazard_pkg;

  // Sequencer state encoding
  localparam logic [2:0] ST_RUN        = 3'd0;
  localparam logic [2:0] ST_DWAIT      = 3'd1;
  localparam logic [2:0] ST_IWAIT      = 3'd2;
  localparam logic [2:0] ST_IWAIT_KILL = 3'd3;
  localparam logic [2:0] ST_HALTED     = 3'd4;

  // Opcodes referenced by the operand-use decode
  localparam logic [4:0] OP_HALT     = 5'b00000;
  localparam logic [4:0] OP_NOP      = 5'b00001;
  localparam logic [4:0] OP_SIIC     = 5'b00010;
  localparam logic [4:0] OP_RTI      = 5'b00011;
  localparam logic [4:0] OP_J        = 5'b00100;
  localparam logic [4:0] OP_JR       = 5'b00101;
  localparam logic [4:0] OP_JAL      = 5'b00110;
  localparam logic [4:0] OP_JALR     = 5'b00111;
  localparam logic [4:0] OP_ST       = 5'b10000;
  localparam logic [4:0] OP_SLBI     = 5'b10010;
  localparam logic [4:0] OP_STU      = 5'b10011;
  localparam logic [4:0] OP_LBI      = 5'b11000;
  localparam logic [4:0] OP_SHIFT_RR = 5'b11010;
  localparam logic [4:0] OP_ALU_RR   = 5'b11011;

  // Three-bit opcode prefixes: conditional branches and set-compare ops
  localparam logic [2:0] OP_BR_PFX   = 3'b011;
  localparam logic [2:0] OP_SET_PFX  = 3'b111;

  // Per-cycle pipeline register control
  typedef struct packed {
    logic hold_pc;
    logic hold_ifid;
    logic hold_idex;
    logic hold_exmem;
    logic bubble_ifid;
    logic bubble_idex;
    logic bubble_memwb;
    logic halted;
  } ctrl_t;

  localparam ctrl_t CTL_NONE   = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTL_HAZARD = ctrl_t'(8'b1100_0100);
  localparam ctrl_t CTL_DWAIT  = ctrl_t'(8'b1111_0010);
  localparam ctrl_t CTL_IWAIT  = ctrl_t'(8'b1000_1000);
  localparam ctrl_t CTL_FLUSH  = ctrl_t'(8'b0000_1100);
  localparam ctrl_t CTL_HALT   = ctrl_t'(8'b1111_0001);

endpackage

// File: rtl/src_use_decode.sv
// rtl/src_use_decode.sv - source-operand use decode for the ID instruction
// Purpose: classify which register operands an opcode reads, and whether Rs is
//          consumed already in ID (branch compare / register jump target).
// Ports:   opcode_i   - 5-bit opcode in ID
//          uses_rs_o  - instruction reads Rs
//          uses_rt_o  - instruction reads Rt
//          early_rs_o - Rs is needed in ID, before forwarding can help
module src_use_decode (
  input  logic [4:0] opcode_i,
  output logic       uses_rs_o,
  output logic       uses_rt_o,
  output logic       early_rs_o
);
  import hazard_pkg::*;

  always_comb begin
    uses_rs_o = 1'b1;
    case (opcode_i)
      OP_HALT, OP_NOP, OP_J, OP_JAL, OP_SIIC, OP_RTI, OP_LBI, OP_SLBI:
        uses_rs_o = 1'b0;
      default: uses_rs_o = 1'b1;
    endcase
  end

  assign uses_rt_o = (opcode_i == OP_ST) || (opcode_i == OP_STU) ||
                     (opcode_i == OP_ALU_RR) || (opcode_i == OP_SHIFT_RR) ||
                     (opcode_i[4:2] == OP_SET_PFX);

  assign early_rs_o = (opcode_i[4:2] == OP_BR_PFX) ||
                      (opcode_i == OP_JR) || (opcode_i == OP_JALR);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hold/bubble/flush sequencer for the 5-stage core
// Purpose: per-cycle control of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//          registers for memory misses, EX redirects, unforwardable hazards
//          and HALT, plus a saturating count of PC-hold cycles.
// Ports:   clk, rst                  - clock, asynchronous active-high reset
//          OpCode_ID, read1/2RegSel_ID - ID instruction opcode and sources
//          Write_register_EX, RegWrite_EX, MemRead_EX, link_EX - EX producer
//          Write_register_MEM, MemRead_MEM - MEM producer
//          imem_stall, imem_done, dmem_stall, dmem_done - memory handshakes
//          redirect_EX, halt_WB      - taken redirect, HALT retiring
//          hold_*, bubble_*, halted  - pipeline register controls
//          stall_cnt                 - cycles with hold_pc high
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       OpCode_ID,
  input  logic [2:0]       read1RegSel_ID,
  input  logic [2:0]       read2RegSel_ID,
  input  logic [2:0]       Write_register_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic             link_EX,
  input  logic [2:0]       Write_register_MEM,
  input  logic             MemRead_MEM,
  input  logic             imem_stall,
  input  logic             imem_done,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  input  logic             redirect_EX,
  input  logic             halt_WB,
  output logic             hold_pc,
  output logic             hold_ifid,
  output logic             hold_idex,
  output logic             hold_exmem,
  output logic             bubble_ifid,
  output logic             bubble_idex,
  output logic             bubble_memwb,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  import hazard_pkg::*;

  logic [2:0]       state_q, state_d;
  logic             kill_q, kill_d;   // DWAIT must resume in IWAIT_KILL
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctl;

  logic uses_rs, uses_rt, early_rs;
  logic rs_match_ex, rt_match_ex, rs_match_mem, hazard;

  src_use_decode u_decode (
    .opcode_i   (OpCode_ID),
    .uses_rs_o  (uses_rs),
    .uses_rt_o  (uses_rt),
    .early_rs_o (early_rs)
  );

  // JAL/JALR write R7 implicitly, so Rs==7 collides even if the EX
  // destination field says otherwise.
  assign rs_match_ex  = (read1RegSel_ID == Write_register_EX) ||
                        ((read1RegSel_ID == 3'd7) && link_EX);
  assign rt_match_ex  = (read2RegSel_ID == Write_register_EX);
  assign rs_match_mem = (read1RegSel_ID == Write_register_MEM);

  // Loads can only forward MEM->EX; an ID-stage Rs consumer cannot be
  // forwarded from EX at all, nor from a load still in MEM.
  assign hazard = (MemRead_EX && RegWrite_EX &&
                   ((uses_rs && rs_match_ex) || (uses_rt && rt_match_ex))) ||
                  (early_rs && RegWrite_EX && rs_match_ex) ||
                  (early_rs && MemRead_MEM && rs_match_mem);

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    ctl     = CTL_NONE;
    case (state_q)
      ST_RUN, ST_IWAIT, ST_IWAIT_KILL: begin
        if (dmem_stall) begin
          ctl     = CTL_DWAIT;
          state_d = ST_DWAIT;
          kill_d  = (state_q == ST_IWAIT_KILL);
        end else if (state_q == ST_IWAIT_KILL) begin
          // The in-flight fetch is wrong-path: always discard it, and only
          // let the PC take the target once the memory is free.
          ctl.bubble_ifid = 1'b1;
          if (imem_done) state_d = ST_RUN;
          else           ctl.hold_pc = 1'b1;
        end else if (redirect_EX) begin
          ctl = CTL_FLUSH;
          if ((state_q == ST_IWAIT) && !imem_done) begin
            ctl.hold_pc = 1'b1;
            state_d     = ST_IWAIT_KILL;
          end else begin
            state_d = ST_RUN;
          end
        end else if (hazard) begin
          ctl = CTL_HAZARD;
          // PC is held, so a fetch completing now is simply re-issued.
          if ((state_q == ST_IWAIT) && imem_done) state_d = ST_RUN;
        end else if (state_q == ST_IWAIT) begin
          if (imem_done) state_d = ST_RUN;
          else           ctl = CTL_IWAIT;
        end else if (imem_stall) begin
          ctl     = CTL_IWAIT;
          state_d = ST_IWAIT;
        end
      end
      ST_DWAIT: begin
        ctl = CTL_DWAIT;
        if (dmem_done) begin
          if (kill_q)          state_d = ST_IWAIT_KILL;
          else if (imem_stall) state_d = ST_IWAIT;
          else                 state_d = ST_RUN;
        end
      end
      ST_HALTED: ctl = CTL_HALT;
      default:   state_d = ST_RUN;
    endcase
    if (halt_WB) state_d = ST_HALTED;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ctl.hold_pc && (state_q != ST_HALTED) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hold_pc      = ctl.hold_pc      & ~rst;
  assign hold_ifid    = ctl.hold_ifid    & ~rst;
  assign hold_idex    = ctl.hold_idex    & ~rst;
  assign hold_exmem   = ctl.hold_exmem   & ~rst;
  assign bubble_ifid  = ctl.bubble_ifid  & ~rst;
  assign bubble_idex  = ctl.bubble_idex  & ~rst;
  assign bubble_memwb = ctl.bubble_memwb & ~rst;
  assign halted       = ctl.halted       & ~rst;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [4:0] OPC_NOP  = 5'b00001;
  localparam logic [4:0] OPC_J    = 5'b00100;
  localparam logic [4:0] OPC_JR   = 5'b00101;
  localparam logic [4:0] OPC_ADDI = 5'b01000;
  localparam logic [4:0] OPC_BEQZ = 5'b01100;
  localparam logic [4:0] OPC_ST   = 5'b10000;
  localparam logic [4:0] OPC_ADD  = 5'b11011;

  // {hold_pc,hold_ifid,hold_idex,hold_exmem,bubble_ifid,bubble_idex,bubble_memwb,halted}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_HAZ  = 8'b1100_0100;
  localparam logic [7:0] V_DW   = 8'b1111_0010;
  localparam logic [7:0] V_RD   = 8'b0000_1100;
  localparam logic [7:0] V_IW   = 8'b1000_1000;
  localparam logic [7:0] V_IWR  = 8'b1000_1100;
  localparam logic [7:0] V_KD   = 8'b0000_1000;
  localparam logic [7:0] V_HLT  = 8'b1111_0001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] OpCode_ID;
  logic [2:0] read1RegSel_ID, read2RegSel_ID, Write_register_EX, Write_register_MEM;
  logic RegWrite_EX, MemRead_EX, link_EX, MemRead_MEM;
  logic imem_stall, imem_done, dmem_stall, dmem_done, redirect_EX, halt_WB;
  logic hold_pc, hold_ifid, hold_idex, hold_exmem;
  logic bubble_ifid, bubble_idex, bubble_memwb, halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [7:0] obs_vec;

  typedef struct {
    logic [7:0]       vec;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  logic [CNT_W-1:0] model_cnt;
  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .OpCode_ID(OpCode_ID), .read1RegSel_ID(read1RegSel_ID), .read2RegSel_ID(read2RegSel_ID),
    .Write_register_EX(Write_register_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .link_EX(link_EX), .Write_register_MEM(Write_register_MEM), .MemRead_MEM(MemRead_MEM),
    .imem_stall(imem_stall), .imem_done(imem_done), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .redirect_EX(redirect_EX), .halt_WB(halt_WB),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid), .hold_idex(hold_idex), .hold_exmem(hold_exmem),
    .bubble_ifid(bubble_ifid), .bubble_idex(bubble_idex), .bubble_memwb(bubble_memwb),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  assign obs_vec = {hold_pc, hold_ifid, hold_idex, hold_exmem,
                    bubble_ifid, bubble_idex, bubble_memwb, halted};

  always #5 clk = ~clk;

  task automatic idle();
    OpCode_ID = OPC_NOP; read1RegSel_ID = 3'd0; read2RegSel_ID = 3'd0;
    Write_register_EX = 3'd6; RegWrite_EX = 1'b0; MemRead_EX = 1'b0; link_EX = 1'b0;
    Write_register_MEM = 3'd6; MemRead_MEM = 1'b0;
    imem_stall = 1'b0; imem_done = 1'b0; dmem_stall = 1'b0; dmem_done = 1'b0;
    redirect_EX = 1'b0; halt_WB = 1'b0;
  endtask

  // Push the expectation for the current inputs, compare at the falling
  // edge, then advance the bench's stall counter model.
  task automatic step(input string tag, input logic [7:0] vec);
    exp_t e;
    e.vec = vec;
    e.cnt = model_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    assert (obs_vec === e.vec) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs_vec, e.vec);
    end
    checks++;
    assert (stall_cnt === e.cnt) else begin
      failures++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, e.cnt);
    end
    if (e.vec[7] && !e.vec[0] && (model_cnt != {CNT_W{1'b1}}))
      model_cnt = model_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_cnt = '0;
    step("reset", V_IDLE);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_cnt = '0;
    idle();
    step("por", V_IDLE);
    rst = 1'b0;
    step("run_idle", V_IDLE);

    // Load-use on Rs: one bubble
    do_reset();
    OpCode_ID = OPC_ADD; read1RegSel_ID = 3'd1; read2RegSel_ID = 3'd3;
    Write_register_EX = 3'd1; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    step("lu_stall", V_HAZ);
    idle(); OpCode_ID = OPC_ADD; read1RegSel_ID = 3'd1; read2RegSel_ID = 3'd3;
    Write_register_MEM = 3'd1; MemRead_MEM = 1'b1;
    step("lu_clear", V_IDLE);

    // Branch after ALU producer: one bubble
    do_reset();
    OpCode_ID = OPC_BEQZ; read1RegSel_ID = 3'd4;
    Write_register_EX = 3'd4; RegWrite_EX = 1'b1;
    step("br_alu", V_HAZ);
    idle(); OpCode_ID = OPC_BEQZ; read1RegSel_ID = 3'd4; Write_register_MEM = 3'd4;
    step("br_alu_clr", V_IDLE);

    // Branch after load: two bubbles
    do_reset();
    OpCode_ID = OPC_BEQZ; read1RegSel_ID = 3'd4;
    Write_register_EX = 3'd4; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    step("br_ld1", V_HAZ);
    idle(); OpCode_ID = OPC_BEQZ; read1RegSel_ID = 3'd4;
    Write_register_MEM = 3'd4; MemRead_MEM = 1'b1;
    step("br_ld2", V_HAZ);
    idle(); OpCode_ID = OPC_BEQZ; read1RegSel_ID = 3'd4;
    step("br_ld_cnt2", V_IDLE);

    // Operand-use decode corner cases
    do_reset();
    OpCode_ID = OPC_JR; read1RegSel_ID = 3'd7; Write_register_EX = 3'd0;
    RegWrite_EX = 1'b1; link_EX = 1'b1;
    step("jr_link", V_HAZ);
    idle(); OpCode_ID = OPC_J; read1RegSel_ID = 3'd2;
    Write_register_EX = 3'd2; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    step("j_no_rs", V_IDLE);
    idle(); OpCode_ID = OPC_ST; read1RegSel_ID = 3'd2; read2RegSel_ID = 3'd5;
    Write_register_EX = 3'd5; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    step("st_rt", V_HAZ);
    idle(); OpCode_ID = OPC_ADDI; read1RegSel_ID = 3'd2; read2RegSel_ID = 3'd5;
    Write_register_EX = 3'd5; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    step("addi_no_rt", V_IDLE);

    // Data miss with redirect pending throughout
    do_reset();
    dmem_stall = 1'b1; redirect_EX = 1'b1;
    step("dw1", V_DW);
    step("dw2", V_DW);
    step("dw3", V_DW);
    dmem_done = 1'b1;
    step("dw4_done", V_DW);
    idle(); redirect_EX = 1'b1;
    step("dw_redirect", V_RD);
    idle();
    step("dw_after", V_IDLE);

    // Instruction miss, redirect on second wait cycle
    do_reset();
    imem_stall = 1'b1;
    step("iw1", V_IW);
    redirect_EX = 1'b1;
    step("iw_redirect", V_IWR);
    idle(); imem_stall = 1'b1;
    step("kill1", V_IW);
    step("kill2", V_IW);
    idle(); imem_done = 1'b1;
    step("kill_done", V_KD);
    idle();
    step("kill_after", V_IDLE);

    // Plain instruction miss
    do_reset();
    imem_stall = 1'b1;
    step("iw_plain", V_IW);
    idle(); imem_done = 1'b1;
    step("iw_plain_done", V_IDLE);

    // Data miss inside IWAIT_KILL resumes the kill
    do_reset();
    imem_stall = 1'b1;
    step("kd_iw", V_IW);
    redirect_EX = 1'b1;
    step("kd_redirect", V_IWR);
    idle(); imem_stall = 1'b1; dmem_stall = 1'b1;
    step("kd_dw1", V_DW);
    dmem_done = 1'b1;
    step("kd_dw2", V_DW);
    idle(); imem_stall = 1'b1;
    step("kd_back", V_IW);
    idle(); imem_done = 1'b1;
    step("kd_done", V_KD);

    // HALT during a data miss
    do_reset();
    dmem_stall = 1'b1;
    step("h_dw", V_DW);
    halt_WB = 1'b1;
    step("h_dw_halt", V_DW);
    idle(); dmem_done = 1'b1; redirect_EX = 1'b1;
    step("halted1", V_HLT);
    idle(); imem_stall = 1'b1;
    step("halted2", V_HLT);
    do_reset();
    step("h_cleared", V_IDLE);

    // Reset in the middle of a data miss, late completions ignored
    do_reset();
    dmem_stall = 1'b1;
    step("mr_dw", V_DW);
    rst = 1'b1;
    model_cnt = '0;
    step("mr_rst", V_IDLE);
    rst = 1'b0;
    idle(); dmem_done = 1'b1;
    step("mr_late_d", V_IDLE);
    idle(); imem_done = 1'b1;
    step("mr_late_i", V_IDLE);

    // Counter saturation
    do_reset();
    imem_stall = 1'b1;
    for (int i = 0; i < 18; i++) step("sat", V_IW);
    idle(); imem_done = 1'b1;
    step("sat_done", V_IDLE);
    checks++;
    assert (stall_cnt === 4'hF) else begin
      failures++;
      $error("FAIL sat_hold stall_cnt observed=%0d expected=15", stall_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
